// File: rtl/fir_ntap_avg_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fir_ntap_avg_pipe                                               |
// | Brief    : N-tap moving-sum / moving-average FIR with sample-enabled delay |
// |            line, registered pairwise adder tree and window-fill tracking.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fir_ntap_avg_pipe #(
  parameter int W      = 4,
  parameter int TAPS   = 4,
  parameter int SIGNED = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [W-1:0]                 a,
  input  logic                         avg_mode,
  input  logic                         flush,
  output logic [W+$clog2(TAPS)-1:0]    s,
  output logic                         out_valid
);

  localparam int LOG2T = $clog2(TAPS);
  localparam int SW    = W + LOG2T;
  localparam int CW    = $clog2(TAPS + 1);
  localparam int NODES = 2 * TAPS - 1;

  logic [W-1:0]  r_taps [TAPS];
  logic [CW-1:0] r_cnt;
  logic          r_tag_v [LOG2T];
  logic          r_tag_m [LOG2T];
  logic [SW-1:0] r_s;
  logic          r_out_valid;

  // Heap-indexed tree: node n has children 2n+1 and 2n+2, leaves are the taps.
  // The root (node 0) is not stored; it feeds the output register directly.
  logic [SW-1:0] w_node [1:NODES-1];
  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_avg;
  logic [SW-1:0] w_result;
  logic          w_full_next;

  assign w_full_next = (r_cnt >= CW'(TAPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) r_taps[i] <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      for (int i = 0; i < TAPS; i++) r_taps[i] <= '0;
      r_cnt <= '0;
    end else if (in_valid) begin
      r_taps[0] <= a;
      for (int i = 1; i < TAPS; i++) r_taps[i] <= r_taps[i-1];
      if (r_cnt != CW'(TAPS)) r_cnt <= r_cnt + CW'(1);
    end
  end

  for (genvar i = 0; i < TAPS; i++) begin : g_leaf
    if (SIGNED != 0) begin : g_sext
      assign w_node[TAPS-1+i] = {{LOG2T{r_taps[i][W-1]}}, r_taps[i]};
    end else begin : g_zext
      assign w_node[TAPS-1+i] = {{LOG2T{1'b0}}, r_taps[i]};
    end
  end

  for (genvar n = 1; n < TAPS - 1; n++) begin : g_node
    logic [SW-1:0] r_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_q <= '0;
      end else if (flush) begin
        r_q <= '0;
      end else begin
        r_q <= w_node[2*n+1] + w_node[2*n+2];
      end
    end
    assign w_node[n] = r_q;
  end

  assign w_sum = w_node[1] + w_node[2];

  if (SIGNED != 0) begin : g_ashr
    assign w_avg = $signed(w_sum) >>> LOG2T;
  end else begin : g_lshr
    assign w_avg = w_sum >> LOG2T;
  end

  assign w_result = r_tag_m[LOG2T-1] ? w_avg : w_sum;

  // Tags travel alongside the tree so each result carries its own mode and validity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LOG2T; i++) begin
        r_tag_v[i] <= 1'b0;
        r_tag_m[i] <= 1'b0;
      end
      r_out_valid <= 1'b0;
      r_s         <= '0;
    end else if (flush) begin
      for (int i = 0; i < LOG2T; i++) begin
        r_tag_v[i] <= 1'b0;
        r_tag_m[i] <= 1'b0;
      end
      r_out_valid <= 1'b0;
    end else begin
      r_tag_v[0] <= in_valid & w_full_next;
      r_tag_m[0] <= avg_mode;
      for (int i = 1; i < LOG2T; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_m[i] <= r_tag_m[i-1];
      end
      r_out_valid <= r_tag_v[LOG2T-1];
      if (r_tag_v[LOG2T-1]) r_s <= w_result;
    end
  end

  assign s         = r_s;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fir_ntap_avg_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for fir_ntap_avg_pipe: unsigned and signed 4-bit/4-tap instances share
// stimulus and are checked against a window/queue reference model.
module tb_fir_ntap_avg_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] a;
  logic       avg_mode;
  logic       flush;
  logic [5:0] s_u, s_s;
  logic       ov_u, ov_s;

  always #5 clk = ~clk;

  fir_ntap_avg_pipe #(.W(4), .TAPS(4), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .avg_mode(avg_mode),
    .flush(flush), .s(s_u), .out_valid(ov_u)
  );

  fir_ntap_avg_pipe #(.W(4), .TAPS(4), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .avg_mode(avg_mode),
    .flush(flush), .s(s_s), .out_valid(ov_s)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic [5:0] su;
    logic [5:0] ss;
  } res_t;

  res_t       pend[$];
  logic [3:0] hist[$];
  logic       exp_v  = 1'b0;
  logic [5:0] exp_su = '0;
  logic [5:0] exp_ss = '0;

  // Expected result of the current 4-sample window, computed with integer arithmetic.
  function automatic res_t window_result(input bit m);
    res_t r;
    int su = 0;
    int ss = 0;
    foreach (hist[i]) begin
      int v;
      v = int'(hist[i]);
      su += v;
      ss += (v >= 8) ? v - 16 : v;
    end
    if (m) begin
      su = su / 4;
      ss = (ss - (((ss % 4) + 4) % 4)) / 4;
    end
    r.due = 0;
    r.su  = su[5:0];
    r.ss  = ss[5:0];
    return r;
  endfunction

  task automatic drive(input bit v, input logic [3:0] av, input bit m, input bit f);
    res_t r;
    in_valid = v;
    a        = av;
    avg_mode = m;
    flush    = f;
    @(posedge clk);
    cyc++;
    if (f) begin
      hist.delete();
      pend.delete();
    end else if (v) begin
      hist.push_back(av);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4) begin
        r     = window_result(m);
        r.due = cyc + 2;
        pend.push_back(r);
      end
    end
    exp_v = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_v  = 1'b1;
      exp_su = pend[0].su;
      exp_ss = pend[0].ss;
      void'(pend.pop_front());
    end
    #1;
  endtask

  task automatic apply_reset();
    #2;
    reset = 1'b1;
    hist.delete();
    pend.delete();
    exp_v  = 1'b0;
    exp_su = '0;
    exp_ss = '0;
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    a        = 4'd9;
    avg_mode = 1'b0;
    flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (s_u !== 6'd0) begin n_errors++; $display("FAIL reset s_u: got %h expected 00", s_u); end
    if (ov_u !== 1'b0) begin n_errors++; $display("FAIL reset ov_u: got %b expected 0", ov_u); end
    if (s_s !== 6'd0) begin n_errors++; $display("FAIL reset s_s: got %h expected 00", s_s); end
    if (ov_s !== 1'b0) begin n_errors++; $display("FAIL reset ov_s: got %b expected 0", ov_s); end
    n_checks += 4;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_fill();
    logic [3:0] av [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0};
    bit         vv [6] = '{1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      drive(vv[i], av[i], 1'b0, 1'b0);
      if (ov_u !== exp_v) begin n_errors++; $display("FAIL fill ov_u[%0d]: got %b expected %b", i, ov_u, exp_v); end
      if (s_u !== exp_su) begin n_errors++; $display("FAIL fill s_u[%0d]: got %h expected %h", i, s_u, exp_su); end
      if (ov_s !== exp_v) begin n_errors++; $display("FAIL fill ov_s[%0d]: got %b expected %b", i, ov_s, exp_v); end
      if (s_s !== exp_ss) begin n_errors++; $display("FAIL fill s_s[%0d]: got %h expected %h", i, s_s, exp_ss); end
      if (ov_u !== (i == 5)) begin n_errors++; $display("FAIL fill first_valid[%0d]: got %b expected %b", i, ov_u, (i == 5)); end
      n_checks += 5;
    end
    if (s_u !== 6'd10) begin n_errors++; $display("FAIL fill sum: got %0d expected 10", s_u); end
    n_checks++;
  endtask

  task automatic test_gap();
    logic [3:0] av [6] = '{4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    bit         vv [6] = '{1, 0, 0, 1, 0, 0};
    bit         lv [6] = '{0, 0, 1, 0, 0, 1};
    logic [5:0] ls [6] = '{6'd10, 6'd10, 6'd24, 6'd24, 6'd24, 6'd22};
    for (int i = 0; i < 6; i++) begin
      drive(vv[i], av[i], 1'b0, 1'b0);
      if (ov_u !== lv[i]) begin n_errors++; $display("FAIL gap ov_u[%0d]: got %b expected %b", i, ov_u, lv[i]); end
      if (s_u !== ls[i]) begin n_errors++; $display("FAIL gap s_u[%0d]: got %0d expected %0d", i, s_u, ls[i]); end
      if (ov_s !== exp_v) begin n_errors++; $display("FAIL gap ov_s[%0d]: got %b expected %b", i, ov_s, exp_v); end
      if (s_s !== exp_ss) begin n_errors++; $display("FAIL gap s_s[%0d]: got %h expected %h", i, s_s, exp_ss); end
      n_checks += 4;
    end
  endtask

  task automatic test_max_avg();
    logic [3:0] av [12] = '{4'd15, 4'd15, 4'd15, 4'd14, 4'd0, 4'd0,
                            4'd15, 4'd15, 4'd15, 4'd14, 4'd0, 4'd0};
    bit         vv [12] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
    bit         mm [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 12; i++) begin
      drive(vv[i], av[i], mm[i], 1'b0);
      if (ov_u !== exp_v) begin n_errors++; $display("FAIL maxavg ov_u[%0d]: got %b expected %b", i, ov_u, exp_v); end
      if (s_u !== exp_su) begin n_errors++; $display("FAIL maxavg s_u[%0d]: got %h expected %h", i, s_u, exp_su); end
      if (ov_s !== exp_v) begin n_errors++; $display("FAIL maxavg ov_s[%0d]: got %b expected %b", i, ov_s, exp_v); end
      if (s_s !== exp_ss) begin n_errors++; $display("FAIL maxavg s_s[%0d]: got %h expected %h", i, s_s, exp_ss); end
      n_checks += 4;
      if (i == 5) begin
        if (s_u !== 6'h3B) begin n_errors++; $display("FAIL max_sum: got %h expected 3b", s_u); end
        n_checks++;
      end
      if (i == 11) begin
        if (s_u !== 6'd14) begin n_errors++; $display("FAIL max_avg: got %0d expected 14", s_u); end
        n_checks++;
      end
    end
  endtask

  task automatic test_signed();
    logic [3:0] av [18] = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd0, 4'd0,
                            4'd8, 4'd8, 4'd8, 4'd8, 4'd0, 4'd0,
                            4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    bit         vv [18] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
    bit         mm [18] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 18; i++) begin
      drive(vv[i], av[i], mm[i], 1'b0);
      if (ov_s !== exp_v) begin n_errors++; $display("FAIL signed ov_s[%0d]: got %b expected %b", i, ov_s, exp_v); end
      if (s_s !== exp_ss) begin n_errors++; $display("FAIL signed s_s[%0d]: got %h expected %h", i, s_s, exp_ss); end
      if (s_u !== exp_su) begin n_errors++; $display("FAIL signed s_u[%0d]: got %h expected %h", i, s_u, exp_su); end
      n_checks += 3;
    end
  endtask

  task automatic test_signed_literals();
    logic [3:0] av [6];
    logic [5:0] want [3] = '{6'h20, 6'h38, 6'h3F};
    bit         mode [3] = '{0, 1, 1};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 6; i++) av[i] = (t == 2) ? ((i == 0) ? 4'd15 : 4'd0) : 4'd8;
      for (int i = 0; i < 6; i++) drive(i < 4, av[i], mode[t], 1'b0);
      if (s_s !== want[t]) begin n_errors++; $display("FAIL signed_lit[%0d]: got %h expected %h", t, s_s, want[t]); end
      if (ov_s !== 1'b1) begin n_errors++; $display("FAIL signed_lit_ov[%0d]: got %b expected 1", t, ov_s); end
      n_checks += 2;
    end
  endtask

  task automatic test_flush();
    logic [5:0] held;
    bit         lv [7] = '{0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      if (ov_u !== exp_v) begin n_errors++; $display("FAIL preflush ov_u[%0d]: got %b expected %b", i, ov_u, exp_v); end
      if (s_u !== exp_su) begin n_errors++; $display("FAIL preflush s_u[%0d]: got %h expected %h", i, s_u, exp_su); end
      n_checks += 2;
    end
    held = exp_su;
    for (int i = 0; i < 7; i++) begin
      drive((i != 5) && (i != 6) || (i == 0), 4'($urandom_range(0, 15)), 1'b0, i == 0);
      if (ov_u !== lv[i]) begin n_errors++; $display("FAIL flush ov_u[%0d]: got %b expected %b", i, ov_u, lv[i]); end
      if (ov_s !== lv[i]) begin n_errors++; $display("FAIL flush ov_s[%0d]: got %b expected %b", i, ov_s, lv[i]); end
      if (ov_u !== exp_v) begin n_errors++; $display("FAIL flush model_ov[%0d]: got %b expected %b", i, ov_u, exp_v); end
      if (s_u !== exp_su) begin n_errors++; $display("FAIL flush s_u[%0d]: got %h expected %h", i, s_u, exp_su); end
      if (s_s !== exp_ss) begin n_errors++; $display("FAIL flush s_s[%0d]: got %h expected %h", i, s_s, exp_ss); end
      n_checks += 5;
      if (i < 6) begin
        if (s_u !== held) begin n_errors++; $display("FAIL flush hold[%0d]: got %h expected %h", i, s_u, held); end
        n_checks++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_out = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      if (ov_u === 1'b1) n_out++;
      if (ov_u !== exp_v) begin n_errors++; $display("FAIL b2b ov_u[%0d]: got %b expected %b", i, ov_u, exp_v); end
      if (s_u !== exp_su) begin n_errors++; $display("FAIL b2b s_u[%0d]: got %h expected %h", i, s_u, exp_su); end
      if (ov_s !== exp_v) begin n_errors++; $display("FAIL b2b ov_s[%0d]: got %b expected %b", i, ov_s, exp_v); end
      if (s_s !== exp_ss) begin n_errors++; $display("FAIL b2b s_s[%0d]: got %h expected %h", i, s_s, exp_ss); end
      n_checks += 4;
    end
    if (n_out !== 38) begin n_errors++; $display("FAIL b2b result_count: got %0d expected 38", n_out); end
    n_checks++;
  endtask

  task automatic test_random_reset();
    int r;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        apply_reset();
        if (s_u !== 6'd0) begin n_errors++; $display("FAIL async_reset s_u[%0d]: got %h expected 00", i, s_u); end
        if (ov_u !== 1'b0) begin n_errors++; $display("FAIL async_reset ov_u[%0d]: got %b expected 0", i, ov_u); end
        if (s_s !== 6'd0) begin n_errors++; $display("FAIL async_reset s_s[%0d]: got %h expected 00", i, s_s); end
        n_checks += 3;
        #2;
        reset = 1'b0;
      end else begin
        drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $urandom_range(0, 99) < 4);
        if (ov_u !== exp_v) begin n_errors++; $display("FAIL random ov_u[%0d]: got %b expected %b", i, ov_u, exp_v); end
        if (s_u !== exp_su) begin n_errors++; $display("FAIL random s_u[%0d]: got %h expected %h", i, s_u, exp_su); end
        if (ov_s !== exp_v) begin n_errors++; $display("FAIL random ov_s[%0d]: got %b expected %b", i, ov_s, exp_v); end
        if (s_s !== exp_ss) begin n_errors++; $display("FAIL random s_s[%0d]: got %h expected %h", i, s_s, exp_ss); end
        n_checks += 4;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_gap();
    test_max_avg();
    test_signed();
    test_signed_literals();
    test_flush();
    test_back_to_back();
    test_random_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
